// File: rtl/hilo_divider.sv
// Multi-cycle unsigned restoring divider feeding the HI/LO result registers.
// One quotient bit per clock; HI = remainder, LO = quotient on commit.
`timescale 1ns/1ps
module hilo_divider #(
  parameter logic [5:0]  DIVU = 6'b011011,
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] LAST = 5'(ITER - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] div_q, div_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [32:0] trial;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic        start;

  // Restoring step. rem < divisor holds between steps, so a 32-bit difference is exact.
  assign trial = {rem_q, quo_q[31]};

  always_comb begin
    step_rem = trial[31:0];
    step_quo = {quo_q[30:0], 1'b0};
    if (trial >= {1'b0, div_q}) begin
      step_rem = trial[31:0] - div_q;
      step_quo = {quo_q[30:0], 1'b1};
    end
  end

  assign start = (Signal == DIVU) && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    if (start) begin
      quo_d   = dataA;
      div_d   = dataB;
      rem_d   = 32'd0;
      cnt_d   = 5'd0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST) begin
            hi_d    = step_rem;
            lo_d    = step_quo;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      div_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign HiOut = hi_q;
  assign LoOut = lo_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: expected HI/LO pushed on each start,
// popped and compared when done pulses.
`timescale 1ns/1ps
module tb_hilo_divider;

  localparam logic [5:0] DIVU = 6'b011011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic [31:0] HiOut, LoOut;
  logic        busy, done;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        exp_q[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  int          total = 0;
  int          bad = 0;

  hilo_divider #(.DIVU(DIVU), .ITER(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .HiOut  (HiOut),
    .LoOut  (LoOut),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive a DIVU request at a negedge and queue the reference result.
  task automatic request(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    Signal = DIVU;
    dataA  = a;
    dataB  = b;
    if (b == 32'd0) begin
      r.lo = 32'hFFFF_FFFF;
      r.hi = a;
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    exp_q.push_back(r);
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    request(a, b);
    @(posedge clk);
    #1 Signal = '0;
  endtask

  // Follow one divide from just after its start edge to its done pulse.
  // inject>0 drives an ignored DIVU mid-run; chain=1 issues the next request in DONE.
  task automatic wait_done(input string tag, input int inject, input bit chain,
                           input logic [31:0] na, input logic [31:0] nb);
    int   busy_cycles = 0;
    bit   seen = 0;
    res_t r;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(negedge clk);
      if (Signal == DIVU && !done) Signal = '0;
      if (i == 16) begin
        check({tag, "_hold_hi"}, HiOut, last_hi);
        check({tag, "_hold_lo"}, LoOut, last_lo);
      end
      if (inject > 0 && i == inject) begin
        Signal = DIVU;
        dataA  = 32'd9;
        dataB  = 32'd3;
      end
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1;
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd32);
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          check({tag, "_hi"}, HiOut, r.hi);
          check({tag, "_lo"}, LoOut, r.lo);
          last_hi = r.hi;
          last_lo = r.lo;
        end
        if (chain) request(na, nb);
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_done_cleared"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int seen_done;
    // DIVU under reset must do nothing.
    Signal = DIVU;
    dataA  = 32'd77;
    dataB  = 32'd5;
    repeat (3) @(negedge clk);
    check("rst_hi", HiOut, 32'd0);
    check("rst_lo", LoOut, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    Signal = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    start(32'd100, 32'd7);
    wait_done("d100_7", 0, 0, '0, '0);
    check_idle("d100_7");

    start(32'hFFFF_FFFF, 32'd1);
    wait_done("dmax_1", 0, 0, '0, '0);
    start(32'd5, 32'd10);
    wait_done("d5_10", 0, 0, '0, '0);

    start(32'd1234, 32'd0);
    wait_done("d1234_0", 0, 0, '0, '0);
    check_idle("d1234_0");

    // Second DIVU during RUN must be ignored.
    start(32'd100, 32'd7);
    wait_done("ignore", 10, 0, '0, '0);
    check_idle("ignore");

    // Reset mid-run aborts with no commit.
    start(32'd100, 32'd7);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_hi", HiOut, 32'd0);
    check("abort_lo", LoOut, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    last_hi = '0;
    last_lo = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    check("abort_no_commit", 32'(seen_done), 32'd0);
    start(32'd9, 32'd3);
    wait_done("d9_3", 0, 0, '0, '0);

    // Back-to-back: new request issued in the DONE cycle.
    start(32'd100, 32'd7);
    wait_done("b2b_first", 0, 1, 32'd50, 32'd6);
    @(posedge clk);
    #1 Signal = '0;
    wait_done("b2b_second", 0, 0, '0, '0);
    check_idle("b2b");
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
